// File: rtl/load_store_unit_if.sv
// Request/response handshake between the execute stage and the load/store unit.
// The master side is the execute stage; the slave side is the load/store unit.
interface load_store_unit_if #(
    parameter int SIZE = 64,
    parameter int BA   = 9
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [BA-1:0]   req_addr;
    logic [SIZE-1:0] req_wdata;
    logic            resp_valid;
    logic [SIZE-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store front-end: byte-addressed requests onto a doubleword-indexed tri-state memory port.
// Loads extract and extend byte lanes; sub-doubleword stores read-modify-write the whole word.
module load_store_unit #(
    parameter int SIZE       = 64,
    parameter int addr_width = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_unit_if.slave      bus,
    output logic [addr_width-1:0] d_mem_addr,
    output logic                  d_mem_we,
    inout  wire  [SIZE-1:0]       d_mem_data
);
    localparam int BA = addr_width + 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      r_state;
    logic            r_we;
    logic [2:0]      r_f3;
    logic [BA-1:0]   r_addr;
    logic [SIZE-1:0] r_wdata;
    logic [SIZE-1:0] r_rbuf;
    logic            r_err;

    logic            w_accept;
    logic            w_illegal;
    logic            w_misal;
    logic            w_in_err;
    logic [2:0]      w_off;
    logic [7:0]      w_size_mask;
    logic [7:0]      w_bmask;
    logic [SIZE-1:0] w_wshift;
    logic [SIZE-1:0] w_rshift;
    logic [SIZE-1:0] w_merge;
    logic [SIZE-1:0] w_ext;
    logic            w_sx;

    assign bus.req_ready = (r_state == S_IDLE) & ~rst;
    assign w_accept      = bus.req_valid & bus.req_ready;

    // Legality is judged on the incoming request so an error can skip memory entirely.
    always_comb begin
        w_illegal = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
        w_misal   = 1'b0;
        case (bus.req_funct3[1:0])
            2'd0:    w_misal = 1'b0;
            2'd1:    w_misal = bus.req_addr[0];
            2'd2:    w_misal = |bus.req_addr[1:0];
            default: w_misal = |bus.req_addr[2:0];
        endcase
        w_in_err = w_illegal | w_misal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rbuf  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= bus.req_we;
                        r_f3    <= bus.req_funct3;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_err   <= w_in_err;
                        if (w_in_err)
                            r_state <= S_RESP;
                        else if (bus.req_we && bus.req_funct3[1:0] == 2'd3)
                            r_state <= S_WRITE;
                        else
                            r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_rbuf  <= d_mem_data;
                    r_state <= r_we ? S_WRITE : S_RESP;
                end
                S_WRITE: r_state <= S_RESP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_off = r_addr[2:0];

    // Byte-lane mask of the store, shifted to its offset within the doubleword.
    always_comb begin
        case (r_f3[1:0])
            2'd0:    w_size_mask = 8'h01;
            2'd1:    w_size_mask = 8'h03;
            2'd2:    w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
        w_bmask = w_size_mask << w_off;
    end

    assign w_wshift = r_wdata << {w_off, 3'b000};

    for (genvar g = 0; g < 8; g++) begin : g_lane
        assign w_merge[8*g +: 8] = w_bmask[g] ? w_wshift[8*g +: 8] : r_rbuf[8*g +: 8];
    end

    assign w_rshift = r_rbuf >> {w_off, 3'b000};
    assign w_sx     = ~r_f3[2];

    always_comb begin
        case (r_f3[1:0])
            2'd0:    w_ext = {{(SIZE-8){w_sx & w_rshift[7]}},   w_rshift[7:0]};
            2'd1:    w_ext = {{(SIZE-16){w_sx & w_rshift[15]}}, w_rshift[15:0]};
            2'd2:    w_ext = {{(SIZE-32){w_sx & w_rshift[31]}}, w_rshift[31:0]};
            default: w_ext = w_rshift;
        endcase
    end

    assign d_mem_addr = r_addr[BA-1:3];
    // Reset gates the write strobe so an in-flight store never commits.
    assign d_mem_we   = (r_state == S_WRITE) & ~rst;
    assign d_mem_data = d_mem_we ? w_merge : {SIZE{1'bz}};

    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_err   = (r_state == S_RESP) & r_err;
    assign bus.resp_rdata = ((r_state == S_RESP) && !r_err && !r_we) ? w_ext : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors plus random traffic
// compared against a byte-array memory model.
module tb_load_store_unit;
    logic       clk;
    logic       rst;
    logic [5:0] d_mem_addr;
    logic       d_mem_we;
    wire [63:0] d_mem_data;

    load_store_unit_if #(.SIZE(64), .BA(9)) bus ();

    load_store_unit #(.SIZE(64), .addr_width(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .d_mem_addr (d_mem_addr),
        .d_mem_we   (d_mem_we),
        .d_mem_data (d_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read driven only while the unit is not writing.
    logic [63:0] mem [64] = '{default: '0};
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [63:0] pl_data;
    int          wr_count = 0;

    assign d_mem_data = d_mem_we ? 64'bz : mem[d_mem_addr];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (d_mem_we) begin
            mem[d_mem_addr] <= d_mem_data;
            wr_count = wr_count + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Any unit-side drive while the strobe is low would corrupt the read value.
    always @(negedge clk) begin
        if (!d_mem_we) begin
            n_checks++;
            if (d_mem_data !== mem[d_mem_addr]) begin
                n_fail++;
                $display("FAIL port_undriven: data=%h required=%h", d_mem_data, mem[d_mem_addr]);
            end
        end
    end

    // Reference model: flat byte-addressed memory.
    bit [7:0] mb [512];

    function automatic bit ref_err(bit we, bit [2:0] f3, int addr);
        int n = 1 << f3[1:0];
        if (!we && f3 == 3'b111) return 1'b1;
        if (we && f3[2]) return 1'b1;
        return (addr % n) != 0;
    endfunction

    function automatic bit [63:0] ref_load(bit [2:0] f3, int addr);
        int n = 1 << f3[1:0];
        bit [63:0] v = '0;
        for (int b = 0; b < n; b++) v |= 64'(mb[addr + b]) << (8 * b);
        if (!f3[2] && n < 8 && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    function automatic void ref_store(bit [2:0] f3, int addr, bit [63:0] wd);
        int n = 1 << f3[1:0];
        for (int b = 0; b < n; b++) mb[addr + b] = wd[8*b +: 8];
    endfunction

    function automatic bit [63:0] ref_word(int idx);
        bit [63:0] v = '0;
        for (int b = 0; b < 8; b++) v |= 64'(mb[idx*8 + b]) << (8 * b);
        return v;
    endfunction

    function automatic int ref_lat(bit we, bit [2:0] f3, int addr);
        if (ref_err(we, f3, addr)) return 1;
        if (!we || f3[1:0] == 2'd3) return 2;
        return 3;
    endfunction

    task automatic preload(input int idx, input bit [63:0] data);
        @(negedge clk);
        pl_idx = 6'(idx); pl_data = data; pl_en = 1'b1;
        @(posedge clk); #1 pl_en = 1'b0;
        for (int b = 0; b < 8; b++) mb[idx*8 + b] = data[8*b +: 8];
    endtask

    // One request: waits for ready, transfers, then measures cycles to resp_valid.
    task automatic do_req(input bit we, input bit [2:0] f3, input int addr, input bit [63:0] wd,
                          output int wait_cyc, output int lat, output bit [63:0] rd, output bit er);
        wait_cyc = 0; lat = 0; rd = '0; er = 1'b0;
        @(negedge clk);
        while (!bus.req_ready && wait_cyc < 10) begin
            wait_cyc++;
            @(negedge clk);
        end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = 9'(addr); bus.req_wdata = wd;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = c; rd = bus.resp_rdata; er = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen = 0;
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 9'h008; bus.req_wdata = 64'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_reset: got %b want 0", bus.req_ready); end
        bus.req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 64'd0) begin
            n_fail++; $display("FAIL reset_resp: valid=%b err=%b rdata=%h want 0/0/0", bus.resp_valid, bus.resp_err, bus.resp_rdata);
        end
        n_checks++;
        if (d_mem_we !== 1'b0 || d_mem_addr !== 6'd0) begin
            n_fail++; $display("FAIL reset_mem_port: we=%b addr=%0d want 0/0", d_mem_we, d_mem_addr);
        end
        repeat (4) begin @(negedge clk); if (bus.resp_valid) seen++; end
        n_checks++;
        if (seen != 0 || mem[1] !== 64'd0) begin
            n_fail++; $display("FAIL req_during_reset: resp_seen=%0d mem1=%h want 0/0", seen, mem[1]);
        end
    endtask

    task automatic test_spec_vectors();
        int w, l, wr0; bit [63:0] rd; bit er;
        preload(15, 64'h8000_0000_0000_0000);
        do_req(1'b0, 3'b011, 9'h078, 64'd0, w, l, rd, er);
        n_checks++;
        if (l != 2 || er !== 1'b0 || rd !== 64'h8000_0000_0000_0000) begin
            n_fail++; $display("FAIL ld_78: lat=%0d err=%b rdata=%h want 2/0/8000000000000000", l, er, rd);
        end
        do_req(1'b0, 3'b000, 9'h07F, 64'd0, w, l, rd, er);
        n_checks++;
        if (l != 2 || rd !== 64'hFFFF_FFFF_FFFF_FF80) begin
            n_fail++; $display("FAIL lb_7f: lat=%0d rdata=%h want 2/ffffffffffffff80", l, rd);
        end
        do_req(1'b0, 3'b100, 9'h07F, 64'd0, w, l, rd, er);
        n_checks++;
        if (l != 2 || rd !== 64'h0000_0000_0000_0080) begin
            n_fail++; $display("FAIL lbu_7f: lat=%0d rdata=%h want 2/0000000000000080", l, rd);
        end
        preload(10, 64'd50);
        do_req(1'b1, 3'b000, 9'h051, 64'hAB, w, l, rd, er);
        ref_store(3'b000, 9'h051, 64'hAB);
        n_checks++;
        if (l != 3 || er !== 1'b0 || rd !== 64'd0) begin
            n_fail++; $display("FAIL sb_51: lat=%0d err=%b rdata=%h want 3/0/0", l, er, rd);
        end
        n_checks++;
        if (mem[10] !== 64'h0000_0000_0000_AB32) begin
            n_fail++; $display("FAIL sb_51_mem: idx10=%h want 000000000000ab32", mem[10]);
        end
        wr0 = wr_count;
        do_req(1'b1, 3'b010, 9'h052, 64'hFFFF_FFFF, w, l, rd, er);
        n_checks++;
        if (l != 1 || er !== 1'b1 || rd !== 64'd0) begin
            n_fail++; $display("FAIL sw_misaligned: lat=%0d err=%b rdata=%h want 1/1/0", l, er, rd);
        end
        n_checks++;
        if (wr_count != wr0 || mem[10] !== 64'h0000_0000_0000_AB32) begin
            n_fail++; $display("FAIL sw_misaligned_mem: writes=%0d idx10=%h want 0/000000000000ab32", wr_count - wr0, mem[10]);
        end
        do_req(1'b0, 3'b111, 9'h050, 64'd0, w, l, rd, er);
        n_checks++;
        if (l != 1 || er !== 1'b1 || rd !== 64'd0) begin
            n_fail++; $display("FAIL ld_f3_111: lat=%0d err=%b rdata=%h want 1/1/0", l, er, rd);
        end
    endtask

    task automatic test_reset_mid_write();
        int seen = 0;
        preload(11, 64'h1122_3344_5566_7788);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
        bus.req_addr = 9'h05E; bus.req_wdata = 64'h1234;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk); if (bus.resp_valid) seen++;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (d_mem_we !== 1'b0) begin n_fail++; $display("FAIL abort_we: got %b want 0", d_mem_we); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) begin @(negedge clk); if (bus.resp_valid) seen++; end
        n_checks++;
        if (seen != 0 || mem[11] !== 64'h1122_3344_5566_7788) begin
            n_fail++; $display("FAIL abort_store: resp_seen=%0d idx11=%h want 0/1122334455667788", seen, mem[11]);
        end
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 64'd0 ||
            d_mem_we !== 1'b0 || d_mem_addr !== 6'd0) begin
            n_fail++; $display("FAIL abort_outputs: ready=%b err=%b rdata=%h we=%b addr=%0d want 1/0/0/0/0",
                               bus.req_ready, bus.resp_err, bus.resp_rdata, d_mem_we, d_mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        int w, l; bit [63:0] rd; bit er;
        do_req(1'b1, 3'b011, 9'h080, 64'hDEAD_BEEF_0000_0001, w, l, rd, er);
        ref_store(3'b011, 9'h080, 64'hDEAD_BEEF_0000_0001);
        n_checks++;
        if (l != 2 || er !== 1'b0) begin n_fail++; $display("FAIL sd_80: lat=%0d err=%b want 2/0", l, er); end
        do_req(1'b0, 3'b010, 9'h084, 64'd0, w, l, rd, er);
        n_checks++;
        if (w != 0 || l != 2 || rd !== 64'hFFFF_FFFF_DEAD_BEEF) begin
            n_fail++; $display("FAIL lw_84: wait=%0d lat=%0d rdata=%h want 0/2/ffffffffdeadbeef", w, l, rd);
        end
        n_checks++;
        if (mem[16] !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++; $display("FAIL sd_80_mem: idx16=%h want deadbeef00000001", mem[16]);
        end
    endtask

    task automatic test_random();
        int w, l, addr, elat; bit [63:0] rd, wd, erd; bit er, eer, we; bit [2:0] f3;
        for (int i = 0; i < 80; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 256 + $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) addr = addr & ~((1 << f3[1:0]) - 1);
            wd   = {$urandom, $urandom};
            eer  = ref_err(we, f3, addr);
            elat = ref_lat(we, f3, addr);
            erd  = (eer || we) ? 64'd0 : ref_load(f3, addr);
            do_req(we, f3, addr, wd, w, l, rd, er);
            if (!eer && we) ref_store(f3, addr, wd);
            n_checks++;
            if (w != 0 || l != elat || er !== eer || rd !== erd) begin
                n_fail++;
                $display("FAIL rand_%0d we=%b f3=%0d addr=%h: wait=%0d lat=%0d err=%b rdata=%h want 0/%0d/%b/%h",
                         i, we, f3, addr, w, l, er, rd, elat, eer, erd);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (mem[k] !== ref_word(k)) begin
                n_fail++; $display("FAIL rand_mem_%0d: got %h want %h", k, mem[k], ref_word(k));
            end
        end
    endtask

    initial begin
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        test_reset();
        test_spec_vectors();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
